// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response tracking,
// an instruction queue toward decode, and redirect flushing of in-flight fetches.
module fetch_unit #(
    parameter int QUEUE_DEPTH = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_value,
    output logic [ADDR_W-1:0] next_pc_in,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    input  logic              if_ready,
    output logic              err_spurious
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  occupancy;
    logic [PTR_W-1:0]  q_head;
    logic [PTR_W-1:0]  q_tail;
    logic [PTR_W-1:0]  f_head;
    logic [PTR_W-1:0]  f_tail;
    logic [31:0]       q_instr [QUEUE_DEPTH];
    logic [ADDR_W-1:0] q_pc    [QUEUE_DEPTH];
    logic [ADDR_W-1:0] f_pc    [QUEUE_DEPTH];

    logic credit;
    logic issue;
    logic rsp_take;
    logic rsp_drop;
    logic q_push;
    logic q_pop;

    // Credit uses registered counts only, so a pop never frees a slot in the same cycle.
    assign credit         = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_C;
    assign imem_req_valid = credit & ~redirect_valid & ~rst;
    assign imem_req_addr  = {pc_value[ADDR_W-1:2], 2'b00};
    assign issue          = imem_req_valid & imem_req_ready;

    assign rsp_take = imem_rsp_valid & (outstanding != '0);
    assign rsp_drop = rsp_take & ((drop_cnt != '0) | redirect_valid);
    assign q_push   = rsp_take & ~rsp_drop;

    assign if_valid = (occupancy != '0);
    assign if_instr = q_instr[q_head];
    assign if_pc    = q_pc[q_head];
    assign q_pop    = if_valid & if_ready & ~redirect_valid;

    always_comb begin
        next_pc_in = pc_value;
        if (rst) begin
            next_pc_in = '0;
        end else if (redirect_valid) begin
            next_pc_in = redirect_pc;
        end else if (issue) begin
            next_pc_in = pc_value + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding  <= '0;
            drop_cnt     <= '0;
            occupancy    <= '0;
            q_head       <= '0;
            q_tail       <= '0;
            f_head       <= '0;
            f_tail       <= '0;
            err_spurious <= 1'b0;
        end else begin
            outstanding <= outstanding + CNT_W'(issue) - CNT_W'(rsp_take);
            if (issue) begin
                f_tail <= ptr_inc(f_tail);
            end
            if (rsp_take) begin
                f_head <= ptr_inc(f_head);
            end

            // A redirect never coincides with an issue, so everything still in flight is stale.
            if (redirect_valid) begin
                drop_cnt <= outstanding - CNT_W'(rsp_take);
            end else if (rsp_take && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end

            if (redirect_valid) begin
                occupancy <= '0;
                q_head    <= '0;
                q_tail    <= '0;
            end else begin
                if (q_push) begin
                    q_tail <= ptr_inc(q_tail);
                end
                if (q_pop) begin
                    q_head <= ptr_inc(q_head);
                end
                case ({q_push, q_pop})
                    2'b10:   occupancy <= occupancy + 1'b1;
                    2'b01:   occupancy <= occupancy - 1'b1;
                    default: occupancy <= occupancy;
                endcase
            end

            if (imem_rsp_valid && (outstanding == '0)) begin
                err_spurious <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue) begin
            f_pc[f_tail] <= imem_req_addr;
        end
        if (q_push) begin
            q_pc[q_tail]    <= f_pc[f_head];
            q_instr[q_tail] <= imem_rsp_data;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(q_push && (occupancy == FULL_C)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a queue-based model of issued, killed and
// delivered fetches plus a random-latency in-order memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_value;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_ready;

    logic [31:0] next_pc_in, imem_req_addr, if_instr, if_pc;
    logic        imem_req_valid, if_valid, err_spurious;
    logic [31:0] next_pc_4, req_addr_4, if_instr_4, if_pc_4;
    logic        req_valid_4, if_valid_4, err_4;

    fetch_unit #(.QUEUE_DEPTH(2), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .pc_value(pc_value), .next_pc_in(next_pc_in),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_ready(if_ready), .err_spurious(err_spurious)
    );

    // Deeper instance used where 2 outstanding plus a queued entry is needed.
    fetch_unit #(.QUEUE_DEPTH(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(rst), .pc_value(pc_value), .next_pc_in(next_pc_4),
        .imem_req_valid(req_valid_4), .imem_req_addr(req_addr_4),
        .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid_4), .if_instr(if_instr_4),
        .if_pc(if_pc_4), .if_ready(if_ready), .err_spurious(err_4)
    );

    always #5 clk = ~clk;

    localparam int DEPTH = 2;

    typedef struct { logic [31:0] addr; bit killed; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t       infl[$];
    ent_t        dq[$];
    mreq_t       mem_q[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_w[$];
    logic [31:0] pc_reg;
    bit          m_err;
    bit          mem_en, mem_rand;
    int          cyc;
    int          nchk, nerr;

    logic [31:0] o_next, o_addr, o_if_pc, o_if_instr, cur_pc;
    logic        o_req_valid, o_if_valid, o_err;
    logic [31:0] e_next, e_addr, e_if_pc, e_if_instr;
    logic        e_req_valid, e_if_valid, e_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_clear();
        infl.delete(); dq.delete(); mem_q.delete(); got_pc.delete(); got_w.delete();
        pc_reg = 32'h0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
        #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    // One clock of stimulus: memory responds, outputs are sampled at the falling edge,
    // expectations come from the model, then the model advances.
    task automatic step();
        bit    red, e_issue;
        infl_t f;
        cyc++;
        pc_value = pc_reg;
        if (mem_en) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
                (!mem_rand || $urandom_range(0, 3) != 0)) begin
                imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(mem_q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
            end
        end
        @(negedge clk);
        o_next = next_pc_in; o_addr = imem_req_addr; o_req_valid = imem_req_valid;
        o_if_valid = if_valid; o_if_pc = if_pc; o_if_instr = if_instr; o_err = err_spurious;
        cur_pc = pc_reg;
        red = redirect_valid;
        e_req_valid = ((infl.size() + dq.size()) < DEPTH) && !red;
        e_addr = {pc_reg[31:2], 2'b00};
        e_issue = e_req_valid && imem_req_ready;
        e_next = red ? redirect_pc : (e_issue ? pc_reg + 32'd4 : pc_reg);
        e_if_valid = dq.size() > 0;
        e_if_pc = e_if_valid ? dq[0].pc : 32'h0;
        e_if_instr = e_if_valid ? dq[0].w : 32'h0;
        e_err = m_err;

        if (mem_en && imem_rsp_valid && mem_q.size() > 0) mem_q.delete(0);
        if (o_req_valid && imem_req_ready)
            mem_q.push_back('{addr: o_addr, due: cyc + 1 + (mem_rand ? int'($urandom_range(0, 2)) : 0)});
        if (o_if_valid && if_ready && !red) begin
            got_pc.push_back(o_if_pc); got_w.push_back(o_if_instr);
        end

        if (e_if_valid && if_ready && !red) dq.delete(0);
        if (imem_rsp_valid) begin
            if (infl.size() == 0) m_err = 1'b1;
            else begin
                f = infl[0]; infl.delete(0);
                if (!f.killed && !red) dq.push_back('{pc: f.addr, w: imem_rsp_data});
            end
        end
        if (red) begin
            dq.delete();
            foreach (infl[i]) infl[i].killed = 1'b1;
        end
        if (e_issue) infl.push_back('{addr: e_addr, killed: 1'b0});
        pc_reg = e_next;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_value = 32'h1234_5678; imem_req_ready = 1'b1; if_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h55; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++; if (imem_req_valid !== 1'b0) begin nerr++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid); end
        nchk++; if (next_pc_in !== 32'h0) begin nerr++; $display("FAIL reset_next_pc got=%h exp=0", next_pc_in); end
        nchk++; if (if_valid !== 1'b0) begin nerr++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
        nchk++; if (err_spurious !== 1'b0) begin nerr++; $display("FAIL reset_err got=%0b exp=0", err_spurious); end
        @(posedge clk); #1;
        redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_streaming();
        mem_en = 1'b1; mem_rand = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0;
        step();
        nchk++; if (o_req_valid !== 1'b1 || o_addr !== 32'h0) begin nerr++; $display("FAIL stream_first_issue got=%0b/%h exp=1/0", o_req_valid, o_addr); end
        nchk++; if (o_next !== 32'h4) begin nerr++; $display("FAIL stream_next_pc got=%h exp=4", o_next); end
        for (int i = 0; i < 12; i++) begin
            step();
            nchk++; if (o_req_valid !== e_req_valid) begin nerr++; $display("FAIL stream_req_valid cyc=%0d got=%0b exp=%0b", cyc, o_req_valid, e_req_valid); end
            nchk++; if (o_if_valid !== e_if_valid) begin nerr++; $display("FAIL stream_if_valid cyc=%0d got=%0b exp=%0b", cyc, o_if_valid, e_if_valid); end
        end
        nchk++;
        if (got_pc.size() < 3) begin nerr++; $display("FAIL stream_count got=%0d exp>=3", got_pc.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                if (got_pc[i] !== 32'(i * 4) || got_w[i] !== mem_word(32'(i * 4))) begin
                    nerr++; $display("FAIL stream_entry%0d got=%h/%h exp=%h/%h", i, got_pc[i], got_w[i], 32'(i * 4), mem_word(32'(i * 4)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int issues;
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b0;
        issues = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_req_valid) issues++;
            nchk++; if (o_req_valid !== e_req_valid) begin nerr++; $display("FAIL bp_req_valid cyc=%0d got=%0b exp=%0b", cyc, o_req_valid, e_req_valid); end
        end
        nchk++; if (issues != 2) begin nerr++; $display("FAIL bp_issue_count got=%0d exp=2", issues); end
        nchk++; if (o_req_valid !== 1'b0) begin nerr++; $display("FAIL bp_stalled got=%0b exp=0", o_req_valid); end
        nchk++; if (o_next !== cur_pc) begin nerr++; $display("FAIL bp_pc_hold got=%h exp=%h", o_next, cur_pc); end
        if_ready = 1'b1;
        step();
        nchk++; if (o_req_valid !== 1'b0) begin nerr++; $display("FAIL bp_pop_cycle got=%0b exp=0", o_req_valid); end
        step();
        nchk++; if (o_req_valid !== 1'b1 || o_addr !== 32'h8) begin nerr++; $display("FAIL bp_resume got=%0b/%h exp=1/8", o_req_valid, o_addr); end
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset();
        mem_en = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
        step(); step();
        nchk++; if (o_req_valid !== 1'b1 || o_addr !== 32'h4) begin nerr++; $display("FAIL redir_second_issue got=%0b/%h exp=1/4", o_req_valid, o_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        step();
        nchk++; if (o_next !== 32'h100) begin nerr++; $display("FAIL redir_next_pc got=%h exp=100", o_next); end
        nchk++; if (o_req_valid !== 1'b0) begin nerr++; $display("FAIL redir_no_issue got=%0b exp=0", o_req_valid); end
        redirect_valid = 1'b0; mem_en = 1'b1; mem_rand = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            nchk++; if (o_if_valid !== e_if_valid) begin nerr++; $display("FAIL redir_if_valid cyc=%0d got=%0b exp=%0b", cyc, o_if_valid, e_if_valid); end
            if (o_if_valid) begin
                seen = 1'b1;
                nchk++; if (o_if_pc !== 32'h100 || o_if_instr !== mem_word(32'h100)) begin
                    nerr++; $display("FAIL redir_first_entry got=%h/%h exp=100/%h", o_if_pc, o_if_instr, mem_word(32'h100));
                end
            end
        end
        nchk++; if (!seen) begin nerr++; $display("FAIL redir_timeout got=no entry exp=entry 0x100"); end
    endtask

    task automatic test_wrap();
        do_reset();
        mem_en = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b1;
        pc_reg = 32'hFFFF_FFFC;
        step();
        nchk++; if (o_req_valid !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL wrap_issue got=%0b/%h exp=1/fffffffc", o_req_valid, o_addr); end
        nchk++; if (o_next !== 32'h0) begin nerr++; $display("FAIL wrap_next_pc got=%h exp=0", o_next); end
    endtask

    task automatic test_spurious();
        do_reset();
        mem_en = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b0;
        step();
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h0);
        step();
        imem_rsp_data = 32'hDEAD_BEEF;
        step();
        nchk++; if (o_err !== 1'b0) begin nerr++; $display("FAIL spur_early got=%0b exp=0", o_err); end
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            nchk++; if (o_err !== 1'b1 || o_err !== e_err) begin nerr++; $display("FAIL spur_sticky cyc=%0d got=%0b exp=1", cyc, o_err); end
            nchk++; if (o_if_valid !== 1'b1 || o_if_pc !== 32'h0 || o_if_instr !== mem_word(32'h0)) begin
                nerr++; $display("FAIL spur_queue got=%0b/%h/%h exp=1/0/%h", o_if_valid, o_if_pc, o_if_instr, mem_word(32'h0));
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem_en = 1'b0; imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; if_ready = 1'b0;
        pc_value = 32'h40;
        @(posedge clk); #1;
        pc_value = 32'h44; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h40);
        @(posedge clk); #1;
        pc_value = 32'h48; imem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        pc_value = 32'h4C; imem_req_ready = 1'b0;
        @(negedge clk);
        nchk++; if (if_valid_4 !== 1'b1 || if_pc_4 !== 32'h40) begin nerr++; $display("FAIL rmid_setup got=%0b/%h exp=1/40", if_valid_4, if_pc_4); end
        rst = 1'b1;
        #1;
        nchk++; if (if_valid_4 !== 1'b0 || req_valid_4 !== 1'b0 || next_pc_4 !== 32'h0) begin
            nerr++; $display("FAIL rmid_async got=%0b/%0b/%h exp=0/0/0", if_valid_4, req_valid_4, next_pc_4);
        end
        @(posedge clk); #1;
        rst = 1'b0; pc_value = 32'h200; imem_rsp_valid = 1'b1; imem_rsp_data = mem_word(32'h44);
        @(posedge clk); #1;
        imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
        @(negedge clk);
        nchk++; if (err_4 !== 1'b1) begin nerr++; $display("FAIL rmid_stale_rsp got=%0b exp=1", err_4); end
        nchk++; if (req_valid_4 !== 1'b1 || req_addr_4 !== 32'h200) begin nerr++; $display("FAIL rmid_first_issue got=%0b/%h exp=1/200", req_valid_4, req_addr_4); end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        mem_en = 1'b1; mem_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom;
            step();
            nchk++; if (o_req_valid !== e_req_valid) begin nerr++; $display("FAIL rand_req_valid cyc=%0d got=%0b exp=%0b", cyc, o_req_valid, e_req_valid); end
            nchk++; if (o_addr !== e_addr) begin nerr++; $display("FAIL rand_req_addr cyc=%0d got=%h exp=%h", cyc, o_addr, e_addr); end
            nchk++; if (o_next !== e_next) begin nerr++; $display("FAIL rand_next_pc cyc=%0d got=%h exp=%h", cyc, o_next, e_next); end
            nchk++; if (o_if_valid !== e_if_valid) begin nerr++; $display("FAIL rand_if_valid cyc=%0d got=%0b exp=%0b", cyc, o_if_valid, e_if_valid); end
            nchk++; if (o_err !== e_err) begin nerr++; $display("FAIL rand_err cyc=%0d got=%0b exp=%0b", cyc, o_err, e_err); end
            if (e_if_valid) begin
                nchk++; if (o_if_pc !== e_if_pc || o_if_instr !== e_if_instr) begin
                    nerr++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", cyc, o_if_pc, o_if_instr, e_if_pc, e_if_instr);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        nchk = 0; nerr = 0; cyc = 0; mem_en = 1'b0; mem_rand = 1'b0;
        model_clear();
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter QUEUE_DEPTH, default 2: number of instruction-queue entries; also the cap on in-flight requests plus queued entries.
REQ-002 Parameter ADDR_W, default 32: width of all address and PC signals.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_value  input  ADDR_W  current PC from the program counter register.
REQ-006 next_pc_in  output  ADDR_W  next PC driven back into the program counter register.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  ADDR_W  fetch address.
REQ-009 imem_req_ready  input  1  instruction memory accepts the request.
REQ-010 imem_rsp_valid  input  1  instruction word returned; responses arrive in order with latency of 1 or more cycles.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 redirect_valid  input  1  branch or jump redirect.
REQ-013 redirect_pc  input  ADDR_W  redirect target.
REQ-014 if_valid  output  1  decode-side entry valid.
REQ-015 if_instr  output  32  instruction at the queue head.
REQ-016 if_pc  output  ADDR_W  PC of if_instr.
REQ-017 if_ready  input  1  decode consumes the head entry.
REQ-018 err_spurious  output  1  sticky flag: a response arrived with no request outstanding.

Function
REQ-019 A credit SHALL exist when outstanding + occupancy < QUEUE_DEPTH, using the registered counts (no same-cycle pop credit).
REQ-020 imem_req_valid SHALL equal credit AND NOT redirect_valid AND NOT rst.
REQ-021 imem_req_addr SHALL equal {pc_value[ADDR_W-1:2], 2'b00}.
REQ-022 An issue occurs when imem_req_valid and imem_req_ready are both high.
  - On issue, the issued address SHALL be pushed into the in-flight PC FIFO (depth QUEUE_DEPTH).
  - On issue, outstanding SHALL increment.
REQ-023 next_pc_in SHALL be combinational, with this priority:
  - rst high: 0.
  - redirect_valid: redirect_pc.
  - issue: pc_value + 4, wrapping modulo 2^ADDR_W.
  - otherwise: pc_value (PC holds).
REQ-024 On imem_rsp_valid with outstanding > 0, the block SHALL pop the in-flight PC FIFO and decrement outstanding.
  - If drop_cnt > 0: discard the word and decrement drop_cnt.
  - Otherwise: push {PC, word} into the instruction queue.
REQ-025 Latency: a response accepted in cycle N SHALL appear at the queue tail with if_valid high in cycle N+1 at the earliest.
REQ-026 if_valid SHALL be high whenever occupancy > 0; if_instr and if_pc SHALL show the head entry.
REQ-027 The head entry SHALL pop when if_valid and if_ready are both high.
REQ-028 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-029 Queue and FIFO pointers SHALL wrap modulo QUEUE_DEPTH.
REQ-030 The credit rule SHALL make queue overflow unreachable; a push into a full queue SHALL be flagged as an assertion failure.
REQ-031 redirect_valid SHALL take effect in one cycle:
  - Queue flushed (occupancy 0, if_valid low the next cycle).
  - drop_cnt set to outstanding after that cycle's response decrement.
  - No issue that cycle.
REQ-032 A redirect coinciding with a response SHALL cause that response to be dropped.
REQ-033 A redirect coinciding with if_ready SHALL let the flush win; no entry counts as consumed.
REQ-034 A redirect coinciding with issue is impossible because of REQ-020.
REQ-035 imem_rsp_valid with outstanding = 0 SHALL be ignored and SHALL set err_spurious, which stays set until reset.
REQ-036 outstanding and drop_cnt SHALL be clog2(QUEUE_DEPTH)+1 bits wide, SHALL saturate at no boundary, and SHALL never exceed QUEUE_DEPTH.

Reset
REQ-037 While rst is high, asynchronously:
  - if_valid = 0, imem_req_valid = 0, err_spurious = 0.
  - occupancy, outstanding and drop_cnt = 0.
  - All pointers = 0; next_pc_in = 0.
REQ-038 Reset asserted mid-operation SHALL abandon all in-flight requests.
  - Responses arriving after rst deasserts with outstanding = 0 SHALL set err_spurious.
REQ-039 The first issue SHALL occur in the first cycle after rst deasserts in which imem_req_ready is high.

Verification
REQ-040 Streaming:
  - Stimulus: pc_value 0x0 with PC register feedback, imem always ready, 1-cycle latency, if_ready high.
  - Response: issues to 0x0, 0x4 and 0x8; if_pc sequence 0x0, 0x4, 0x8, each with the matching word.
REQ-041 Backpressure:
  - Stimulus: if_ready low, QUEUE_DEPTH 2.
  - Response: after 2 issues imem_req_valid drops and next_pc_in equals pc_value (held); raising if_ready resumes issue the next cycle.
REQ-042 Redirect with traffic in flight:
  - Stimulus: redirect to 0x100 while outstanding = 2.
  - Response: next 2 responses discarded; if_valid low until the 0x100 word arrives; first if_pc 0x100.
REQ-043 Wrap:
  - Stimulus: pc_value 0xFFFFFFFC issued.
  - Response: next_pc_in 0x00000000.
REQ-044 Spurious response:
  - Stimulus: imem_rsp_valid with outstanding = 0.
  - Response: err_spurious rises next cycle and stays high; queue unchanged.
REQ-045 Reset mid-fetch:
  - Stimulus: rst asserted with 2 outstanding and 1 queued entry.
  - Response: if_valid and imem_req_valid go low immediately; after release, first issue address equals pc_value.
